// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch stage.
// Holds the PC, fetches one word per instruction over a ready handshake,
// latches it in the instruction register and computes the next PC from the
// decoder's jump/branch flags and the ALU zero flag.
// Optional feature macro: FETCH_RETIRE_COUNT_EN builds a 32-bit retired
// instruction counter; without it retireCount is tied to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic        instrValid,
    input  logic        advance,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic [31:0] retireCount
);

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        commit;

    // Next-PC candidates derived purely from the PC and instruction registers
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        branch_target = pc_plus4 + branch_offset;
        jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        commit        = (state_q == ST_HOLD) && advance;
    end

    // State transitions, instruction capture and PC commit; jump outranks branch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imemReady) begin
                    instr_d = imemData;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (commit) begin
                    state_d = ST_FETCH;
                    if (jump) begin
                        pc_d = jump_target;
                    end else if (branch && zero) begin
                        pc_d = branch_target;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Architectural state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0] retire_count_q, retire_count_d;

    // Retired count advances once per committed instruction and wraps naturally
    always_comb begin
        retire_count_d = retire_count_q;
        if (commit) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            retire_count_q <= 32'h0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retireCount = retire_count_q;
`else
    assign retireCount = 32'h0;
`endif

    // Handshake and status outputs decode only from registered state
    assign imemReq    = (state_q == ST_FETCH);
    assign imemAddr   = pc_q;
    assign instrValid = (state_q == ST_HOLD);
    assign instr      = instr_q;
    assign opCode     = instr_q[31:26];
    assign pc         = pc_q;
    assign pcPlus4    = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with RESET_PC = 32'h100.
// Walks the PC through jumps, taken/untaken branches, region crossing and
// 32-bit wrap, with hand-computed expected values.
module tb_fetch_unit;

    logic        clk;
    logic        resetN;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic [5:0]  opCode;
    logic        instrValid;
    logic        advance;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] retireCount;

    int total;
    int bad;
    int retired;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemData   (imemData),
        .instr      (instr),
        .opCode     (opCode),
        .instrValid (instrValid),
        .advance    (advance),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .retireCount(retireCount)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] expRetire(input int n);
`ifdef FETCH_RETIRE_COUNT_EN
        return 32'(n);
`else
        return 32'h0;
`endif
    endfunction

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    // Wait waitCycles in FETCH, then present the word with imemReady for one cycle
    task automatic fetchWord(input logic [31:0] data, input int waitCycles);
        imemData  = data;
        imemReady = 1'b0;
        repeat (waitCycles) stepCycle;
        imemReady = 1'b1;
        stepCycle;
        imemReady = 1'b0;
        checkOutput("fetchValid", {31'b0, instrValid}, 32'h1);
        checkOutput("fetchInstr", instr, data);
    endtask

    // Commit the held instruction with the given decoder flags
    task automatic applyStimulus(input logic b, input logic z, input logic j);
        branch  = b;
        zero    = z;
        jump    = j;
        advance = 1'b1;
        stepCycle;
        advance = 1'b0;
        branch  = 1'b0;
        zero    = 1'b0;
        jump    = 1'b0;
        retired++;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        retired   = 0;
        resetN    = 1'b0;
        imemReady = 1'b0;
        imemData  = 32'h0;
        advance   = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
        jump      = 1'b0;

        repeat (2) stepCycle;
        checkOutput("rstPc", pc, 32'h100);
        checkOutput("rstReq", {31'b0, imemReq}, 32'h0);
        checkOutput("rstValid", {31'b0, instrValid}, 32'h0);
        checkOutput("rstInstr", instr, 32'h0);
        checkOutput("rstOpCode", {26'b0, opCode}, 32'h0);
        checkOutput("rstRetire", retireCount, 32'h0);

        resetN = 1'b1;
        stepCycle;
        checkOutput("relReq", {31'b0, imemReq}, 32'h1);
        checkOutput("relAddr", imemAddr, 32'h100);

        // advance during FETCH must be ignored
        advance = 1'b1;
        stepCycle;
        advance = 1'b0;
        checkOutput("advInFetchPc", pc, 32'h100);
        checkOutput("advInFetchReq", {31'b0, imemReq}, 32'h1);

        // lw with three wait states
        imemData = 32'h8C22_0004;
        repeat (3) stepCycle;
        checkOutput("waitNoValid", {31'b0, instrValid}, 32'h0);
        fetchWord(32'h8C22_0004, 0);
        checkOutput("lwOpCode", {26'b0, opCode}, 32'h23);
        checkOutput("holdNoReq", {31'b0, imemReq}, 32'h0);

        // imemReady during HOLD must not disturb instr
        imemData  = 32'hDEAD_BEEF;
        imemReady = 1'b1;
        stepCycle;
        imemReady = 1'b0;
        checkOutput("readyInHold", instr, 32'h8C22_0004);

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("seqAddr", imemAddr, 32'h104);
        checkOutput("seqReq", {31'b0, imemReq}, 32'h1);
        checkOutput("seqValid", {31'b0, instrValid}, 32'h0);

        // asynchronous reset in the middle of FETCH
        resetN = 1'b0;
        #1;
        retired = 0;
        checkOutput("midRstPc", pc, 32'h100);
        checkOutput("midRstReq", {31'b0, imemReq}, 32'h0);
        checkOutput("midRstValid", {31'b0, instrValid}, 32'h0);
        #2;
        resetN    = 1'b1;
        imemData  = 32'h0800_0010;
        imemReady = 1'b1;
        stepCycle;
        checkOutput("lateReadyValid", {31'b0, instrValid}, 32'h0);
        checkOutput("lateReadyInstr", instr, 32'h0);
        checkOutput("lateReadyRetire", retireCount, 32'h0);

        // j 0x10 -> 0x40
        fetchWord(32'h0800_0010, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("jmpTo40", pc, 32'h40);

        // beq imm=-1 taken -> stays at 0x40
        fetchWord(32'h1022_FFFF, 1);
        checkOutput("beqOpCode", {26'b0, opCode}, 32'h04);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("beqTaken", pc, 32'h40);

        // same beq, zero clear -> fall through
        fetchWord(32'h1022_FFFF, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("beqNotTaken", pc, 32'h44);

        // j 0 -> 0x0
        fetchWord(32'h0800_0000, 2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("jmpTo0", pc, 32'h0);

        // beq imm=-2 from 0 -> 4 - 8 = 0xFFFFFFFC
        fetchWord(32'h1022_FFFE, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("backBranch", pc, 32'hFFFF_FFFC);
        checkOutput("plus4Wrap", pcPlus4, 32'h0);
        checkOutput("retire5", retireCount, expRetire(5));

        // plain advance wraps to 0
        fetchWord(32'h0000_0000, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pcWrap", pc, 32'h0);
        checkOutput("pcWrapAddr", imemAddr, 32'h0);

        // j 0x3FFFFFF -> end of region 0
        fetchWord(32'h0BFF_FFFF, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("jmpRegionEnd", pc, 32'h0FFF_FFFC);

        fetchWord(32'h0000_0000, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("crossRegion", pc, 32'h1000_0000);

        // jump wins over a taken branch
        fetchWord(32'h0800_0010, 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("jmpPriority", pc, 32'h1000_0040);
        checkOutput("jmpPlus4", pcPlus4, 32'h1000_0044);
        checkOutput("retireFinal", retireCount, expRetire(retired));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
